// File: rtl/ray_coord_issuer.sv
// ---------------------------------------------------------------------------
// ray_coord_issuer
//
// Front-end sequencer for ray_unit. Walks the screen in raster order and
// issues one signed fixed-point (screen_x, screen_y) pair per pixel as a
// one-cycle coords_valid pulse. ray_unit cannot stall, so issue is gated by
// an in-flight credit counter that is returned by ray_unit's result_valid.
// frame_done pulses once every issued ray of the frame has come back.
//
// Optional feature (macro RAY_COORD_ISSUER_PERF_EN):
//   frame_cycles : cycles from leaving IDLE up to and including the
//                  frame_done cycle, saturating, held until the next start.
//   stall_cycles : RUN cycles in which issue was blocked by a full credit
//                  counter.
//   Both are cleared by rst and by an accepted start.
//
// Ports:
//   clk           clock
//   rst           asynchronous, active-high reset
//   start         begin a frame (accepted only in IDLE)
//   result_valid  one pulse per ray returned by ray_unit
//   screen_x/y    signed fp coordinate of the issued pixel (held otherwise)
//   coords_valid  one-cycle pulse per issued pixel
//   pix_x/pix_y   integer column/row of the issued pixel (held otherwise)
//   inflight      number of outstanding rays
//   busy          high while a frame is running or draining
//   frame_done    one-cycle pulse at end of frame
//   credit_err    sticky: a result arrived while no ray was outstanding
// ---------------------------------------------------------------------------
module ray_coord_issuer #(
   parameter  int H_RES        = 640,
   parameter  int V_RES        = 480,
   parameter  int FP_WIDTH     = 32,
   parameter  int FRAC_BITS    = 16,
   parameter  int STEP_FP      = 273,
   parameter  int MAX_INFLIGHT = 8,
   localparam int PX_W         = (H_RES > 1) ? $clog2(H_RES) : 1,
   localparam int PY_W         = (V_RES > 1) ? $clog2(V_RES) : 1,
   localparam int IF_W         = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       result_valid,
   output logic signed [FP_WIDTH-1:0] screen_x,
   output logic signed [FP_WIDTH-1:0] screen_y,
   output logic                       coords_valid,
   output logic [PX_W-1:0]            pix_x,
   output logic [PY_W-1:0]            pix_y,
   output logic [IF_W-1:0]            inflight,
   output logic                       busy,
   output logic                       frame_done,
   output logic                       credit_err
`ifdef RAY_COORD_ISSUER_PERF_EN
   ,
   output logic [31:0]                frame_cycles,
   output logic [31:0]                stall_cycles
`endif
);

   // Screen spans [-1,1] vertically; both starts truncate toward zero.
   localparam int X_START_I = -((H_RES - 1) * STEP_FP) / 2;
   localparam int Y_START_I = (H_RES > 0) ? ((V_RES - 1) * STEP_FP) / 2 : 0;

   localparam logic signed [FP_WIDTH-1:0] X_START = FP_WIDTH'(X_START_I);
   localparam logic signed [FP_WIDTH-1:0] Y_START = FP_WIDTH'(Y_START_I);
   localparam logic signed [FP_WIDTH-1:0] STEP    = FP_WIDTH'(STEP_FP);

   localparam logic [PX_W-1:0] PX_LAST = PX_W'(H_RES - 1);
   localparam logic [PY_W-1:0] PY_LAST = PY_W'(V_RES - 1);
   localparam logic [IF_W-1:0] IF_MAX  = IF_W'(MAX_INFLIGHT);

   if (MAX_INFLIGHT < 1 || FRAC_BITS >= FP_WIDTH) begin : g_param_check
      $error("ray_coord_issuer: illegal parameter combination");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t                      r_state;
   state_t                      w_state_nxt;
   logic                        w_frame_done_nxt;

   logic [PX_W-1:0]             r_pix_x;
   logic [PY_W-1:0]             r_pix_y;
   logic signed [FP_WIDTH-1:0]  r_x_acc;
   logic signed [FP_WIDTH-1:0]  r_y_acc;
   logic [IF_W-1:0]             r_inflight;

   logic                        r_coords_valid;
   logic signed [FP_WIDTH-1:0]  r_screen_x;
   logic signed [FP_WIDTH-1:0]  r_screen_y;
   logic [PX_W-1:0]             r_out_pix_x;
   logic [PY_W-1:0]             r_out_pix_y;
   logic                        r_frame_done;
   logic                        r_credit_err;

   logic                        w_start;
   logic                        w_issue;
   logic                        w_line_end;
   logic                        w_last;
   logic                        w_drain_empty;

   assign w_start    = (r_state == S_IDLE) && start;
   // Registered count only: a same-cycle return cannot enable an issue.
   assign w_issue    = (r_state == S_RUN) && (r_inflight < IF_MAX);
   assign w_line_end = (r_pix_x == PX_LAST);
   assign w_last     = w_issue && w_line_end && (r_pix_y == PY_LAST);
   // The last ray may be returning in this very cycle.
   assign w_drain_empty = (r_inflight == '0) ||
                          ((r_inflight == IF_W'(1)) && result_valid);

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a value unassigned and no latch is inferred.
      w_state_nxt      = r_state;
      w_frame_done_nxt = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            if (w_last) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (w_drain_empty) begin
               w_state_nxt      = S_IDLE;
               w_frame_done_nxt = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Raster walk and coordinate accumulators
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments only, so
         // every register samples the pre-edge value of its neighbours.
         r_pix_x <= '0;
         r_pix_y <= '0;
         r_x_acc <= '0;
         r_y_acc <= '0;
      end else if (w_start) begin
         r_pix_x <= '0;
         r_pix_y <= '0;
         r_x_acc <= X_START;
         r_y_acc <= Y_START;
      end else if (w_issue) begin
         if (w_line_end) begin
            r_pix_x <= '0;
            r_x_acc <= X_START;
            r_y_acc <= r_y_acc - STEP;
            r_pix_y <= w_last ? '0 : r_pix_y + PY_W'(1);
         end else begin
            r_pix_x <= r_pix_x + PX_W'(1);
            r_x_acc <= r_x_acc + STEP;
         end
      end
   end

   // ------------------------------------------------------------------
   // Issue registers: capture the current pixel, hold between pulses
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_coords_valid <= 1'b0;
         r_screen_x     <= '0;
         r_screen_y     <= '0;
         r_out_pix_x    <= '0;
         r_out_pix_y    <= '0;
         r_frame_done   <= 1'b0;
      end else begin
         r_coords_valid <= w_issue;
         r_frame_done   <= w_frame_done_nxt;
         if (w_issue) begin
            r_screen_x  <= r_x_acc;
            r_screen_y  <= r_y_acc;
            r_out_pix_x <= r_pix_x;
            r_out_pix_y <= r_pix_y;
         end
      end
   end

   // ------------------------------------------------------------------
   // Credit counter. Issue is bounded by IF_MAX and a return at zero is
   // dropped, so the count can never wrap.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_inflight   <= '0;
         r_credit_err <= 1'b0;
      end else begin
         case ({w_issue, result_valid})
            2'b10: r_inflight <= r_inflight + IF_W'(1);
            2'b01: begin
               if (r_inflight != '0) begin
                  r_inflight <= r_inflight - IF_W'(1);
               end else begin
                  r_credit_err <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign screen_x     = r_screen_x;
   assign screen_y     = r_screen_y;
   assign coords_valid = r_coords_valid;
   assign pix_x        = r_out_pix_x;
   assign pix_y        = r_out_pix_y;
   assign inflight     = r_inflight;
   assign busy         = (r_state != S_IDLE);
   assign frame_done   = r_frame_done;
   assign credit_err   = r_credit_err;

`ifdef RAY_COORD_ISSUER_PERF_EN
   // ------------------------------------------------------------------
   // Performance counters. Each busy cycle adds one; the closing edge adds
   // one more so the frame_done cycle itself is included in the total.
   // ------------------------------------------------------------------
   logic [31:0] r_frame_cycles;
   logic [31:0] r_stall_cycles;
   logic [32:0] w_frame_sum;

   assign w_frame_sum = {1'b0, r_frame_cycles} + (w_frame_done_nxt ? 33'd2 : 33'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_frame_cycles <= '0;
         r_stall_cycles <= '0;
      end else if (w_start) begin
         r_frame_cycles <= '0;
         r_stall_cycles <= '0;
      end else begin
         if (r_state != S_IDLE) begin
            r_frame_cycles <= w_frame_sum[32] ? '1 : w_frame_sum[31:0];
         end
         if ((r_state == S_RUN) && (r_inflight == IF_MAX) && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
         end
      end
   end

   assign frame_cycles = r_frame_cycles;
   assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_ray_coord_issuer.sv
// ---------------------------------------------------------------------------
// tb_ray_coord_issuer
//
// Small-screen bench (4x2 pixels, 1.0 step). DUT a (8 credits) runs full
// frames with a 3-cycle result echo and is checked by a scoreboard fed from
// a raster reference model; DUT b (2 credits) exercises the credit limit.
// With RAY_COORD_ISSUER_PERF_EN, DUT c (1 credit, 1-cycle echo) exercises
// the performance counters.
// ---------------------------------------------------------------------------
module tb_ray_coord_issuer;

   localparam int H    = 4;
   localparam int V    = 2;
   localparam int STEP = 65536;

   typedef struct {
      longint x;
      longint y;
      longint px;
      longint py;
   } pix_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // DUT a: 8 credits
   // ------------------------------------------------------------------
   logic               start_a = 1'b0, rv_a = 1'b0;
   logic signed [31:0] sx_a, sy_a;
   logic               cv_a, busy_a, fd_a, cerr_a;
   logic [1:0]         px_a;
   logic [0:0]         py_a;
   logic [3:0]         inf_a;

   ray_coord_issuer #(.H_RES(H), .V_RES(V), .FP_WIDTH(32), .FRAC_BITS(16),
                      .STEP_FP(STEP), .MAX_INFLIGHT(8)) u_dut_a (
      .clk(clk), .rst(rst), .start(start_a), .result_valid(rv_a),
      .screen_x(sx_a), .screen_y(sy_a), .coords_valid(cv_a),
      .pix_x(px_a), .pix_y(py_a), .inflight(inf_a), .busy(busy_a),
      .frame_done(fd_a), .credit_err(cerr_a)
`ifdef RAY_COORD_ISSUER_PERF_EN
      , .frame_cycles(), .stall_cycles()
`endif
   );

   // ------------------------------------------------------------------
   // DUT b: 2 credits
   // ------------------------------------------------------------------
   logic               start_b = 1'b0, rv_b = 1'b0;
   logic signed [31:0] sx_b, sy_b;
   logic               cv_b, busy_b, fd_b, cerr_b;
   logic [1:0]         px_b;
   logic [0:0]         py_b;
   logic [1:0]         inf_b;

   ray_coord_issuer #(.H_RES(H), .V_RES(V), .FP_WIDTH(32), .FRAC_BITS(16),
                      .STEP_FP(STEP), .MAX_INFLIGHT(2)) u_dut_b (
      .clk(clk), .rst(rst), .start(start_b), .result_valid(rv_b),
      .screen_x(sx_b), .screen_y(sy_b), .coords_valid(cv_b),
      .pix_x(px_b), .pix_y(py_b), .inflight(inf_b), .busy(busy_b),
      .frame_done(fd_b), .credit_err(cerr_b)
`ifdef RAY_COORD_ISSUER_PERF_EN
      , .frame_cycles(), .stall_cycles()
`endif
   );

`ifdef RAY_COORD_ISSUER_PERF_EN
   // ------------------------------------------------------------------
   // DUT c: 1 credit, performance counters
   // ------------------------------------------------------------------
   logic               start_c = 1'b0, rv_c = 1'b0;
   logic signed [31:0] sx_c, sy_c;
   logic               cv_c, busy_c, fd_c, cerr_c;
   logic [1:0]         px_c;
   logic [0:0]         py_c;
   logic [0:0]         inf_c;
   logic [31:0]        fcyc_c, stall_c;

   ray_coord_issuer #(.H_RES(H), .V_RES(V), .FP_WIDTH(32), .FRAC_BITS(16),
                      .STEP_FP(STEP), .MAX_INFLIGHT(1)) u_dut_c (
      .clk(clk), .rst(rst), .start(start_c), .result_valid(rv_c),
      .screen_x(sx_c), .screen_y(sy_c), .coords_valid(cv_c),
      .pix_x(px_c), .pix_y(py_c), .inflight(inf_c), .busy(busy_c),
      .frame_done(fd_c), .credit_err(cerr_c),
      .frame_cycles(fcyc_c), .stall_cycles(stall_c)
   );

   logic [7:0] hist_c = '0;
   initial forever begin
      @(negedge clk);
      if (rst) hist_c = '0;
      else begin
         hist_c = {hist_c[6:0], cv_c};
         rv_c   = hist_c[1];
      end
   end
`endif

   // ------------------------------------------------------------------
   // Reference model: the whole frame in raster order
   // ------------------------------------------------------------------
   pix_t exp_q[$];

   task automatic push_frame();
      pix_t p;
      for (int py = 0; py < V; py++) begin
         for (int px = 0; px < H; px++) begin
            p.x  = -((H - 1) * STEP) / 2 + px * STEP;
            p.y  = ((V - 1) * STEP) / 2 - py * STEP;
            p.px = px;
            p.py = py;
            exp_q.push_back(p);
         end
      end
   endtask

   // ------------------------------------------------------------------
   // Responder for DUT a: echo each issue 3 cycles later when enabled
   // ------------------------------------------------------------------
   logic [7:0] hist_a = '0;
   logic       echo_a = 1'b0;
   int         ret_a  = 0;

   initial forever begin
      @(negedge clk);
      if (rst) hist_a = '0;
      else begin
         hist_a = {hist_a[6:0], cv_a};
         if (echo_a) begin
            rv_a = hist_a[3];
            if (hist_a[3]) ret_a++;
         end
      end
   end

   // ------------------------------------------------------------------
   // Monitor / scoreboard for DUT a
   // ------------------------------------------------------------------
   int issued_a = 0;
   int fd_cnt_a = 0;

   initial forever begin
      pix_t e;
      @(negedge clk);
      if (!rst) begin
         if (cv_a) begin
            issued_a++;
            if (exp_q.size() == 0) begin
               check("unexpected_coords_valid", longint'(cv_a), 0);
            end else begin
               e = exp_q.pop_front();
               check("screen_x", longint'(sx_a), e.x);
               check("screen_y", longint'(sy_a), e.y);
               check("pix_x", longint'(px_a), e.px);
               check("pix_y", longint'(py_a), e.py);
            end
         end
         if (fd_a) begin
            fd_cnt_a++;
            check("done_busy_low", longint'(busy_a), 0);
            check("done_inflight", longint'(inf_a), 0);
            check("done_all_issued", exp_q.size(), 0);
            check("done_after_all_results", ret_a, H * V);
         end
      end
   end

   task automatic pulse(ref logic s);
      @(negedge clk);
      s = 1'b1;
      @(negedge clk);
      s = 1'b0;
   endtask

   task automatic wait_fd_a(input int target);
      int k = 0;
      while (fd_cnt_a < target && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("frame_done_count", fd_cnt_a, target);
   endtask

   task automatic check_a_zero(input string tag);
      check({tag, "_cv"},       longint'(cv_a),   0);
      check({tag, "_sx"},       longint'(sx_a),   0);
      check({tag, "_sy"},       longint'(sy_a),   0);
      check({tag, "_px"},       longint'(px_a),   0);
      check({tag, "_py"},       longint'(py_a),   0);
      check({tag, "_inflight"}, longint'(inf_a),  0);
      check({tag, "_busy"},     longint'(busy_a), 0);
      check({tag, "_done"},     longint'(fd_a),   0);
      check({tag, "_cerr"},     longint'(cerr_a), 0);
   endtask

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   initial begin
      int n_b;
      int k;

      // Reset state
      repeat (3) @(negedge clk);
      check_a_zero("reset");
      check("reset_b_inflight", longint'(inf_b), 0);
      @(negedge clk);
      #2 rst = 1'b0;

      // Raster frame with a 3-cycle echo; first pulse two cycles after start
      push_frame();
      ret_a  = 0;
      echo_a = 1'b1;
      @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      check("latency_not_yet", longint'(cv_a), 0);
      @(negedge clk);
      check("latency_first_pulse", longint'(cv_a), 1);
      wait_fd_a(1);
      check("frame1_pulses", issued_a, H * V);
      check("hold_screen_x", longint'(sx_a), 98304);
      check("hold_screen_y", longint'(sy_a), -32768);

      // Start pulsed mid-RUN must be ignored
      push_frame();
      ret_a    = 0;
      issued_a = 0;
      pulse(start_a);
      k = 0;
      while (issued_a < 3 && k < 50) begin
         @(negedge clk);
         k++;
      end
      pulse(start_a);
      wait_fd_a(2);
      repeat (20) @(negedge clk);
      check("ignored_start_done_count", fd_cnt_a, 2);
      check("ignored_start_pulses", issued_a, H * V);

      // Credit limit on DUT b: results held off
      n_b = 0;
      @(negedge clk);
      start_b = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         start_b = 1'b0;
         if (cv_b) n_b++;
      end
      check("credit_pulses", n_b, 2);
      check("credit_inflight_full", longint'(inf_b), 2);
      check("credit_busy", longint'(busy_b), 1);
      rv_b = 1'b1;
      @(negedge clk);
      rv_b = 1'b0;
      check("credit_no_issue_yet", longint'(cv_b), 0);
      @(negedge clk);
      check("credit_reissue", longint'(cv_b), 1);
      check("credit_reissue_pix_x", longint'(px_b), 2);
      n_b = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (cv_b) n_b++;
      end
      check("credit_no_extra", n_b, 0);
      check("credit_inflight_refull", longint'(inf_b), 2);

      // Simultaneous issue and return at inflight=1, then reset mid-frame
      echo_a   = 1'b0;
      rv_a     = 1'b0;
      push_frame();
      issued_a = 0;
      pulse(start_a);
      @(negedge clk);
      check("simul_first_issue", longint'(cv_a), 1);
      check("simul_inflight_before", longint'(inf_a), 1);
      rv_a = 1'b1;
      @(negedge clk);
      rv_a = 1'b0;
      check("simul_second_issue", longint'(cv_a), 1);
      check("simul_inflight_kept", longint'(inf_a), 1);
      check("simul_no_cerr", longint'(cerr_a), 0);
      @(negedge clk);
      check("third_issue", issued_a, 3);
      #2 rst = 1'b1;
      #1 check_a_zero("midreset");
      exp_q.delete();
      @(negedge clk);
      #2 rst = 1'b0;

      // Restart after reset begins again at pixel 0
      push_frame();
      ret_a    = 0;
      issued_a = 0;
      echo_a   = 1'b1;
      pulse(start_a);
      wait_fd_a(3);
      check("restart_pulses", issued_a, H * V);

      // Return while idle with nothing outstanding
      echo_a = 1'b0;
      @(negedge clk);
      rv_a = 1'b1;
      @(negedge clk);
      rv_a = 1'b0;
      check("idle_return_cerr", longint'(cerr_a), 1);
      check("idle_return_inflight", longint'(inf_a), 0);
      repeat (3) @(negedge clk);
      check("cerr_sticky", longint'(cerr_a), 1);

`ifdef RAY_COORD_ISSUER_PERF_EN
      // Performance counters with one credit and a 1-cycle echo
      begin
         int busy_cnt;
         int fcyc_seen;
         busy_cnt = 0;
         k        = 0;
         @(negedge clk);
         start_c = 1'b1;
         @(negedge clk);
         start_c = 1'b0;
         while (!fd_c && k < 300) begin
            if (busy_c) busy_cnt++;
            @(negedge clk);
            k++;
         end
         check("perf_frame_done_seen", longint'(fd_c), 1);
         fcyc_seen = int'(fcyc_c);
         check("perf_frame_cycles", longint'(fcyc_c), busy_cnt + 1);
         check("perf_stall_nonzero", longint'(stall_c != 0), 1);
         repeat (4) @(negedge clk);
         check("perf_frame_cycles_held", longint'(fcyc_c), fcyc_seen);
      end
`endif

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
